// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the pipelined MIPS main control.
package mips_ctrl_pkg;

    // Opcodes understood by the decoder (6-bit MIPS primary opcode values)
    localparam int OP_RTYPE = 0;
    localparam int OP_BEQ   = 4;
    localparam int OP_BNE   = 5;
    localparam int OP_ADDI  = 8;
    localparam int OP_ORI   = 13;
    localparam int OP_LW    = 35;
    localparam int OP_SW    = 43;

    // Base ALU-op encodings; wider ALUOP_W configurations zero-extend these
    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2,
        ALU_OR    = 2'd3
    } aluop_e;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } ctrl_wb_t;

    typedef struct packed {
        logic branch;
        logic branch_ne;
        logic memread;
        logic memwrite;
    } ctrl_m_t;

    typedef struct packed {
        logic   regdst;
        aluop_e aluop;
        logic   alusrc;
    } ctrl_ex_t;

    localparam ctrl_wb_t WB_BUBBLE = '{regwrite: 1'b0, memtoreg: 1'b0};
    localparam ctrl_m_t  M_BUBBLE  = '{branch: 1'b0, branch_ne: 1'b0,
                                       memread: 1'b0, memwrite: 1'b0};
    localparam ctrl_ex_t EX_BUBBLE = '{regdst: 1'b0, aluop: ALU_ADD, alusrc: 1'b0};

endpackage

// File: rtl/mips_ctrl_decode.sv
// ID-stage opcode decoder: opcode -> WB/M/EX control, legality, rt-read flag.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opcode,
    output ctrl_wb_t         wb,
    output ctrl_m_t          m,
    output ctrl_ex_t         ex,
    output logic             legal,
    output logic             reads_rt
);

    // Table decode; anything not listed is illegal and decodes to all zeros
    always_comb begin
        wb       = WB_BUBBLE;
        m        = M_BUBBLE;
        ex       = EX_BUBBLE;
        legal    = 1'b1;
        reads_rt = 1'b0;
        case (opcode)
            OPC_W'(OP_RTYPE): begin
                wb.regwrite = 1'b1;
                ex.regdst   = 1'b1;
                ex.aluop    = ALU_FUNCT;
                reads_rt    = 1'b1;
            end
            OPC_W'(OP_LW): begin
                wb.regwrite = 1'b1;
                wb.memtoreg = 1'b1;
                m.memread   = 1'b1;
                ex.alusrc   = 1'b1;
            end
            OPC_W'(OP_SW): begin
                m.memwrite  = 1'b1;
                ex.alusrc   = 1'b1;
                reads_rt    = 1'b1;
            end
            OPC_W'(OP_BEQ): begin
                m.branch    = 1'b1;
                ex.aluop    = ALU_SUB;
                reads_rt    = 1'b1;
            end
            OPC_W'(OP_BNE): begin
                m.branch    = 1'b1;
                m.branch_ne = 1'b1;
                ex.aluop    = ALU_SUB;
                reads_rt    = 1'b1;
            end
            OPC_W'(OP_ADDI): begin
                wb.regwrite = 1'b1;
                ex.alusrc   = 1'b1;
            end
            OPC_W'(OP_ORI): begin
                wb.regwrite = 1'b1;
                ex.alusrc   = 1'b1;
                ex.aluop    = ALU_OR;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_ctrl_pipe.sv
// Pipelined main control: decode in ID, carry control through ID/EX,
// EX/MEM and MEM/WB, with load-use stall, branch flush and illegal flag.
module mips_ctrl_pipe
    import mips_ctrl_pkg::*;
#(
    parameter int OPC_W     = 6,
    parameter int REG_AW    = 5,
    parameter int ALUOP_W   = 2,   // must be >= 2
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [OPC_W-1:0]   id_opcode,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               flush_i,
    output logic               stall_o,
    output logic               pc_write_o,
    output logic               ifid_write_o,
    output logic               ex_regdst,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_alusrc,
    output logic [REG_AW-1:0]  ex_dst,
    output logic               mem_branch,
    output logic               mem_branch_ne,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic [REG_AW-1:0]  mem_dst,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [REG_AW-1:0]  wb_dst,
    output logic               illegal_o
);

    ctrl_wb_t dec_wb;
    ctrl_m_t  dec_m;
    ctrl_ex_t dec_ex;
    logic     dec_legal;
    logic     dec_reads_rt;

    mips_ctrl_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode   (id_opcode),
        .wb       (dec_wb),
        .m        (dec_m),
        .ex       (dec_ex),
        .legal    (dec_legal),
        .reads_rt (dec_reads_rt)
    );

    // ID/EX
    ctrl_wb_t            idex_wb;
    ctrl_m_t             idex_m;
    ctrl_ex_t            idex_ex;
    logic [REG_AW-1:0]   idex_dst;
    // EX/MEM
    ctrl_wb_t            exmem_wb;
    ctrl_m_t             exmem_m;
    logic [REG_AW-1:0]   exmem_dst;
    // MEM/WB
    ctrl_wb_t            memwb_wb;
    logic [REG_AW-1:0]   memwb_dst;

    logic                hazard;
    logic                id_bubble;
    logic [REG_AW-1:0]   id_dst;
    logic                illegal_q;

    // Destination select; instructions that do not write a register carry dst 0
    // so that downstream forwarding/hazard compares never match them.
    always_comb begin
        id_dst = '0;
        if (dec_wb.regwrite)
            id_dst = dec_ex.regdst ? id_rd : id_rt;
    end

    // Load-use hazard: load in EX whose destination is read by the ID instruction.
    // r0 is never a hazard source since its dst is 0 whenever nothing is written.
    always_comb begin
        hazard = 1'b0;
        if (HAZARD_EN)
            hazard = idex_m.memread && (idex_dst != '0) && id_valid &&
                     ((idex_dst == id_rs) || (dec_reads_rt && (idex_dst == id_rt)));
    end

    assign stall_o      = hazard & ~rst;
    assign pc_write_o   = ~stall_o;
    assign ifid_write_o = ~stall_o;

    assign id_bubble = flush_i || !id_valid || !dec_legal || hazard;

    // ID/EX register: bubble on flush, stall, idle slot or illegal opcode
    always_ff @(posedge clk) begin
        if (rst || id_bubble) begin
            idex_wb  <= WB_BUBBLE;
            idex_m   <= M_BUBBLE;
            idex_ex  <= EX_BUBBLE;
            idex_dst <= '0;
        end else begin
            idex_wb  <= dec_wb;
            idex_m   <= dec_m;
            idex_ex  <= dec_ex;
            idex_dst <= id_dst;
        end
    end

    // EX/MEM register: flush kills the instruction that was in EX
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            exmem_wb  <= WB_BUBBLE;
            exmem_m   <= M_BUBBLE;
            exmem_dst <= '0;
        end else begin
            exmem_wb  <= idex_wb;
            exmem_m   <= idex_m;
            exmem_dst <= idex_dst;
        end
    end

    // MEM/WB register: the resolving branch itself still retires on a flush
    always_ff @(posedge clk) begin
        if (rst) begin
            memwb_wb  <= WB_BUBBLE;
            memwb_dst <= '0;
        end else begin
            memwb_wb  <= exmem_wb;
            memwb_dst <= exmem_dst;
        end
    end

    // Sticky illegal flag; an opcode being flushed away does not count
    always_ff @(posedge clk) begin
        if (rst)
            illegal_q <= 1'b0;
        else if (id_valid && !dec_legal && !flush_i)
            illegal_q <= 1'b1;
    end

    assign ex_regdst     = idex_ex.regdst;
    assign ex_aluop      = ALUOP_W'(idex_ex.aluop);
    assign ex_alusrc     = idex_ex.alusrc;
    assign ex_dst        = idex_dst;
    assign mem_branch    = exmem_m.branch;
    assign mem_branch_ne = exmem_m.branch_ne;
    assign mem_memread   = exmem_m.memread;
    assign mem_memwrite  = exmem_m.memwrite;
    assign mem_dst       = exmem_dst;
    assign wb_regwrite   = memwb_wb.regwrite;
    assign wb_memtoreg   = memwb_wb.memtoreg;
    assign wb_dst        = memwb_dst;
    assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// Directed bench for mips_ctrl_pipe with hand-computed expectations.
module tb_mips_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       flush_i;
    logic       stall_o, pc_write_o, ifid_write_o;
    logic       ex_regdst, ex_alusrc;
    logic [1:0] ex_aluop;
    logic [4:0] ex_dst, mem_dst, wb_dst;
    logic       mem_branch, mem_branch_ne, mem_memread, mem_memwrite;
    logic       wb_regwrite, wb_memtoreg, illegal_o;

    int checks   = 0;
    int failures = 0;

    mips_ctrl_pipe dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush_i(flush_i),
        .stall_o(stall_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
        .ex_regdst(ex_regdst), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
        .ex_dst(ex_dst), .mem_branch(mem_branch), .mem_branch_ne(mem_branch_ne),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_dst(mem_dst),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_dst(wb_dst),
        .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Move past the next rising edge; outputs are then sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [5:0] op,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
    endtask

    // Empty the pipeline with idle slots
    task automatic drain();
        set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        repeat (3) tick();
    endtask

    function automatic logic [31:0] ex_bits();
        return 32'({ex_regdst, ex_aluop, ex_alusrc, ex_dst});
    endfunction
    function automatic logic [31:0] mem_bits();
        return 32'({mem_branch, mem_branch_ne, mem_memread, mem_memwrite, mem_dst});
    endfunction
    function automatic logic [31:0] wb_bits();
        return 32'({wb_regwrite, wb_memtoreg, wb_dst});
    endfunction

    // {regdst, aluop[1:0], alusrc, regwrite, memtoreg, branch, branch_ne, memread, memwrite}
    logic [9:0] dtab [7];
    logic [5:0] otab [7];

    initial begin
        otab[0] = 6'd0;  dtab[0] = 10'b1_10_0_1_0_0_0_0_0;
        otab[1] = 6'd35; dtab[1] = 10'b0_00_1_1_1_0_0_1_0;
        otab[2] = 6'd43; dtab[2] = 10'b0_00_1_0_0_0_0_0_1;
        otab[3] = 6'd4;  dtab[3] = 10'b0_01_0_0_0_1_0_0_0;
        otab[4] = 6'd5;  dtab[4] = 10'b0_01_0_0_0_1_1_0_0;
        otab[5] = 6'd8;  dtab[5] = 10'b0_00_1_1_0_0_0_0_0;
        otab[6] = 6'd13; dtab[6] = 10'b0_11_1_1_0_0_0_0_0;

        rst     = 1'b1;
        flush_i = 1'b0;
        set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();

        // Reset state
        chk("rst_ex", ex_bits(), 32'd0);
        chk("rst_mem", mem_bits(), 32'd0);
        chk("rst_wb", wb_bits(), 32'd0);
        chk("rst_illegal", 32'(illegal_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_pcw", 32'({pc_write_o, ifid_write_o}), 32'b11);
        rst = 1'b0;

        // R-type stream
        set_id(1'b1, 6'd0, 5'd1, 5'd2, 5'd3);
        tick();
        chk("rtype_ex", ex_bits(), 32'({1'b1, 2'd2, 1'b0, 5'd3}));
        set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("rtype_mem", mem_bits(), 32'({4'b0000, 5'd3}));
        tick();
        chk("rtype_wb", wb_bits(), 32'({1'b1, 1'b0, 5'd3}));

        // Decode table sweep: each opcode walked through EX, MEM and WB
        for (int i = 0; i < 7; i++) begin
            logic [4:0] rt, rd, dst;
            rt  = 5'(10 + i);
            rd  = 5'(20 + i);
            dst = dtab[i][5] ? (dtab[i][9] ? rd : rt) : 5'd0;
            set_id(1'b1, otab[i], 5'd0, rt, rd);
            tick();
            chk($sformatf("dec_ex_op%0d", otab[i]), ex_bits(), 32'({dtab[i][9:6], dst}));
            set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
            tick();
            chk($sformatf("dec_mem_op%0d", otab[i]), mem_bits(), 32'({dtab[i][3:0], dst}));
            tick();
            chk($sformatf("dec_wb_op%0d", otab[i]), wb_bits(), 32'({dtab[i][5:4], dst}));
        end

        // Load-use: LW r5 then R-type reading r5 via rs
        set_id(1'b1, 6'd35, 5'd0, 5'd5, 5'd9);
        tick();
        chk("lu_ex_lw", ex_bits(), 32'({1'b0, 2'd0, 1'b1, 5'd5}));
        set_id(1'b1, 6'd0, 5'd5, 5'd6, 5'd7);
        #1;
        chk("lu_stall", 32'(stall_o), 32'd1);
        chk("lu_pcw", 32'({pc_write_o, ifid_write_o}), 32'b00);
        tick();
        chk("lu_bubble_ex", ex_bits(), 32'd0);
        chk("lu_mem_lw", mem_bits(), 32'({4'b0010, 5'd5}));
        chk("lu_stall_once", 32'(stall_o), 32'd0);
        tick();
        chk("lu_ex_late", ex_bits(), 32'({1'b1, 2'd2, 1'b0, 5'd7}));
        chk("lu_mem_bubble", mem_bits(), 32'd0);
        drain();

        // No false hazard: LW into r0 followed by an r0 reader
        set_id(1'b1, 6'd35, 5'd0, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 6'd0, 5'd0, 5'd0, 5'd4);
        #1;
        chk("nh_r0", 32'(stall_o), 32'd0);
        drain();

        // LW r5 then ADDI with rt=5 (rt is written, not read)
        set_id(1'b1, 6'd35, 5'd0, 5'd5, 5'd0);
        tick();
        set_id(1'b1, 6'd8, 5'd1, 5'd5, 5'd0);
        #1;
        chk("nh_addi", 32'(stall_o), 32'd0);
        tick();
        chk("nh_addi_ex", ex_bits(), 32'({1'b0, 2'd0, 1'b1, 5'd5}));
        drain();

        // LW r7 then SW reading r7 via rt: real hazard
        set_id(1'b1, 6'd35, 5'd0, 5'd7, 5'd0);
        tick();
        set_id(1'b1, 6'd43, 5'd0, 5'd7, 5'd0);
        #1;
        chk("hz_sw_rt", 32'(stall_o), 32'd1);
        drain();

        // Flush: ADDI, BEQ, SW in flight, LW in ID when the branch resolves
        set_id(1'b1, 6'd8, 5'd0, 5'd11, 5'd0);
        tick();
        set_id(1'b1, 6'd4, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(1'b1, 6'd43, 5'd3, 5'd4, 5'd0);
        tick();
        chk("fl_pre_mem", mem_bits(), 32'({4'b1000, 5'd0}));
        chk("fl_pre_ex", ex_bits(), 32'({1'b0, 2'd0, 1'b1, 5'd0}));
        chk("fl_pre_wb", wb_bits(), 32'({1'b1, 1'b0, 5'd11}));
        set_id(1'b1, 6'd35, 5'd1, 5'd6, 5'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        chk("fl_ex", ex_bits(), 32'd0);
        chk("fl_mem", mem_bits(), 32'd0);
        chk("fl_wb", wb_bits(), 32'd0);
        drain();

        // Flush and load-use hazard in the same cycle
        set_id(1'b1, 6'd35, 5'd0, 5'd5, 5'd0);
        tick();
        set_id(1'b1, 6'd0, 5'd5, 5'd1, 5'd2);
        flush_i = 1'b1;
        #1;
        chk("fh_stall", 32'(stall_o), 32'd1);
        tick();
        flush_i = 1'b0;
        set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        chk("fh_ex", ex_bits(), 32'd0);
        chk("fh_mem", mem_bits(), 32'd0);
        chk("fh_illegal", 32'(illegal_o), 32'd0);

        // Illegal opcode that is being flushed does not set the flag
        set_id(1'b1, 6'd63, 5'd0, 5'd0, 5'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("ill_flushed", 32'(illegal_o), 32'd0);

        // Illegal opcode: sticky flag and a bubble in EX
        set_id(1'b1, 6'd63, 5'd1, 5'd2, 5'd3);
        tick();
        chk("ill_set", 32'(illegal_o), 32'd1);
        chk("ill_ex", ex_bits(), 32'd0);
        set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        chk("ill_sticky", 32'(illegal_o), 32'd1);

        // Reset mid-stream with a hazard pending in ID
        set_id(1'b1, 6'd0, 5'd1, 5'd2, 5'd3);
        tick();
        set_id(1'b1, 6'd35, 5'd0, 5'd5, 5'd0);
        tick();
        set_id(1'b1, 6'd0, 5'd5, 5'd6, 5'd7);
        rst = 1'b1;
        #1;
        chk("mr_stall", 32'(stall_o), 32'd0);
        chk("mr_pcw", 32'({pc_write_o, ifid_write_o}), 32'b11);
        tick();
        chk("mr_ex", ex_bits(), 32'd0);
        chk("mr_mem", mem_bits(), 32'd0);
        chk("mr_wb", wb_bits(), 32'd0);
        chk("mr_illegal", 32'(illegal_o), 32'd0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
